// File: rtl/sync_fifo_param_pkg.sv
// Shared width helpers and parameter legality check for the parametrised FIFO.
package sync_fifo_pkg;

  // Pointer width never collapses to zero, even when DEPTH == 2.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int level_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  function automatic bit params_ok(input int width, input int depth,
                                   input int afull_th, input int aempty_th);
    return (width >= 1) && (depth >= 2) &&
           (afull_th >= 1) && (afull_th <= depth) &&
           (aempty_th >= 0) && (aempty_th <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer-facing bundle of the FIFO; master is the user side, slave is the FIFO.
interface sync_fifo_param_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 12
);
  logic                         flush_i;
  logic                         clr_err_i;
  logic                         wr_en_i;
  logic [WIDTH-1:0]             wr_data_i;
  logic                         rd_en_i;
  logic [WIDTH-1:0]             rd_data_o;
  logic                         rd_valid_o;
  logic                         empty_o;
  logic                         full_o;
  logic                         almost_empty_o;
  logic                         almost_full_o;
  logic [$clog2(DEPTH+1)-1:0]   level_o;
  logic                         overflow_o;
  logic                         underflow_o;

  modport master (
    output flush_i, clr_err_i, wr_en_i, wr_data_i, rd_en_i,
    input  rd_data_o, rd_valid_o, empty_o, full_o, almost_empty_o,
           almost_full_o, level_o, overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, clr_err_i, wr_en_i, wr_data_i, rd_en_i,
    output rd_data_o, rd_valid_o, empty_o, full_o, almost_empty_o,
           almost_full_o, level_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/sync_fifo_param_wrap_ptr.sv
// Wrapping index counter: counts 0..DEPTH-1 and returns to 0, valid for any DEPTH >= 2.
module fifo_wrap_ptr
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = 12,
  parameter int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic             inc,
  input  logic             clr,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with level-derived flags, sticky errors, flush and optional FWFT read.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 12,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  sync_fifo_param_if.slave bus
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int LVL_W = level_width(DEPTH);
  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AFULL  = LVL_W'(AFULL_TH);
  localparam logic [LVL_W-1:0] LVL_AEMPTY = LVL_W'(AEMPTY_TH);

  if (!params_ok(WIDTH, DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
    $error("sync_fifo_param: illegal WIDTH/DEPTH/threshold parameters");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             empty;
  logic             full;
  logic             rd_acc;
  logic             wr_acc;
  logic             rd_pop;
  logic             wr_push;
  logic             ovf_q;
  logic             udf_q;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_FULL);
  assign rd_acc  = bus.rd_en_i & ~empty;
  // A full FIFO still takes a write when the same cycle frees a slot.
  assign wr_acc  = bus.wr_en_i & (~full | rd_acc);
  assign rd_pop  = rd_acc & ~bus.flush_i;
  assign wr_push = wr_acc & ~bus.flush_i;

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk_sys_i  (clk_sys_i),
    .rst_sys_ni (rst_sys_ni),
    .inc        (wr_push),
    .clr        (bus.flush_i),
    .ptr        (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk_sys_i  (clk_sys_i),
    .rst_sys_ni (rst_sys_ni),
    .inc        (rd_pop),
    .clr        (bus.flush_i),
    .ptr        (rd_ptr)
  );

  always_ff @(posedge clk_sys_i) begin
    if (wr_push) begin
      mem[wr_ptr] <= bus.wr_data_i;
    end
  end

  always_comb begin
    level_d = level_q;
    case ({wr_push, rd_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      level_q <= '0;
    end else if (bus.flush_i) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  // A fresh error in the same cycle as clr_err_i keeps the flag set.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (bus.flush_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.wr_en_i & ~wr_acc)  ovf_q <= 1'b1;
      else if (bus.clr_err_i)     ovf_q <= 1'b0;
      if (bus.rd_en_i & ~rd_acc)  udf_q <= 1'b1;
      else if (bus.clr_err_i)     udf_q <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.rd_data_o  = mem[rd_ptr];
    assign bus.rd_valid_o = ~empty;
  end else begin : g_reg_read
    logic [WIDTH-1:0] rd_data_p1;
    logic             vld_p1;

    // Registered read stage: head captured on each accepted pop.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
        rd_data_p1 <= '0;
        vld_p1     <= 1'b0;
      end else begin
        vld_p1 <= rd_pop;
        if (rd_pop) begin
          rd_data_p1 <= mem[rd_ptr];
        end
      end
    end

    assign bus.rd_data_o  = rd_data_p1;
    assign bus.rd_valid_o = vld_p1;
  end

  assign bus.empty_o        = empty;
  assign bus.full_o         = full;
  assign bus.almost_empty_o = (level_q <= LVL_AEMPTY);
  assign bus.almost_full_o  = (level_q >= LVL_AFULL);
  assign bus.level_o        = level_q;
  assign bus.overflow_o     = ovf_q;
  assign bus.underflow_o    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: default registered-read FIFO plus a small FWFT instance.
module tb_sync_fifo_param;

  localparam int D = 12;

  logic clk_sys_i = 1'b0;
  logic rst_sys_ni;
  always #5 clk_sys_i = ~clk_sys_i;

  sync_fifo_param_if #(.WIDTH(32), .DEPTH(D)) bus ();
  sync_fifo_param_if #(.WIDTH(8),  .DEPTH(5)) bus_f ();

  sync_fifo_param #(.WIDTH(32), .DEPTH(D)) dut (
    .clk_sys_i  (clk_sys_i),
    .rst_sys_ni (rst_sys_ni),
    .bus        (bus)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(5), .AFULL_TH(3), .AEMPTY_TH(2), .FWFT(1)) dut_f (
    .clk_sys_i  (clk_sys_i),
    .rst_sys_ni (rst_sys_ni),
    .bus        (bus_f)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb [$];
  bit          m_ovf = 1'b0;
  bit          m_udf = 1'b0;
  logic [31:0] m_rd  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.wr_en_i = 1'b0; bus.rd_en_i = 1'b0; bus.flush_i = 1'b0; bus.clr_err_i = 1'b0;
    bus.wr_data_i = '0;
    bus_f.wr_en_i = 1'b0; bus_f.rd_en_i = 1'b0; bus_f.flush_i = 1'b0; bus_f.clr_err_i = 1'b0;
    bus_f.wr_data_i = '0;
  endtask

  task automatic check_main(input string tag, input bit vexp);
    chk({tag, ".level"}, 32'(bus.level_o), 32'(sb.size()));
    chk({tag, ".empty"}, 32'(bus.empty_o), 32'(sb.size() == 0));
    chk({tag, ".full"},  32'(bus.full_o),  32'(sb.size() == D));
    chk({tag, ".aempty"}, 32'(bus.almost_empty_o), 32'(sb.size() <= 2));
    chk({tag, ".afull"},  32'(bus.almost_full_o),  32'(sb.size() >= D - 2));
    chk({tag, ".ovf"},   32'(bus.overflow_o),  32'(m_ovf));
    chk({tag, ".udf"},   32'(bus.underflow_o), 32'(m_udf));
    chk({tag, ".rvalid"}, 32'(bus.rd_valid_o), 32'(vexp));
    chk({tag, ".rdata"}, bus.rd_data_o, m_rd);
  endtask

  // One clock of stimulus on the registered-read FIFO, with the scoreboard updated alongside.
  task automatic step(input string tag, input bit wr, input logic [31:0] d, input bit rd,
                      input bit fl = 1'b0, input bit ce = 1'b0);
    bit ra, wa, vexp;
    bus.wr_en_i = wr; bus.wr_data_i = d; bus.rd_en_i = rd;
    bus.flush_i = fl; bus.clr_err_i = ce;
    if (fl) begin
      sb.delete(); m_ovf = 1'b0; m_udf = 1'b0; vexp = 1'b0;
    end else begin
      ra = rd && (sb.size() > 0);
      wa = wr && ((sb.size() < D) || ra);
      if (ra) m_rd = sb.pop_front();
      if (wa) sb.push_back(d);
      m_ovf = (wr && !wa) ? 1'b1 : (ce ? 1'b0 : m_ovf);
      m_udf = (rd && !ra) ? 1'b1 : (ce ? 1'b0 : m_udf);
      vexp  = ra;
    end
    @(posedge clk_sys_i); #1;
    idle_inputs();
    check_main(tag, vexp);
  endtask

  task automatic fstep(input bit wr, input logic [7:0] d, input bit rd);
    bus_f.wr_en_i = wr; bus_f.wr_data_i = d; bus_f.rd_en_i = rd;
    @(posedge clk_sys_i); #1;
    idle_inputs();
  endtask

  initial begin
    rst_sys_ni = 1'b0;
    idle_inputs();
    #1;
    check_main("reset", 1'b0);
    chk("f_reset.empty", 32'(bus_f.empty_o), 32'd1);
    chk("f_reset.rvalid", 32'(bus_f.rd_valid_o), 32'd0);
    repeat (2) @(posedge clk_sys_i);
    #1 rst_sys_ni = 1'b1;

    for (int i = 0; i < D; i++) step("fill", 1'b1, 32'(i), 1'b0);
    step("overflow", 1'b1, 32'hFF, 1'b0);
    for (int i = 0; i < D; i++) step("drain", 1'b0, '0, 1'b1);
    step("underflow", 1'b0, '0, 1'b1);
    step("clr_err", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 5; i++) step("wrap_pre", 1'b1, 32'h100 + 32'(i), 1'b0);
    for (int i = 0; i < 20; i++) step("wrap", 1'b1, 32'h200 + 32'(i), 1'b1);
    for (int i = 0; i < 5; i++) step("wrap_post", 1'b0, '0, 1'b1);

    for (int i = 0; i < D; i++) step("sfill", 1'b1, 32'h300 + 32'(i), 1'b0);
    step("sim_full", 1'b1, 32'hAA, 1'b1);
    for (int i = 0; i < D; i++) step("sdrain", 1'b0, '0, 1'b1);

    for (int i = 0; i < D; i++) step("ffill", 1'b1, 32'h400 + 32'(i), 1'b0);
    step("fovf", 1'b1, 32'hBB, 1'b0);
    for (int i = 0; i < 5; i++) step("fread", 1'b0, '0, 1'b1);
    step("flush", 1'b1, 32'hCC, 1'b0, 1'b1);
    step("post_flush", 1'b0, '0, 1'b1);
    step("post_flush_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 32'h500 + 32'(i), 1'b0);
    step("pre_rst_rd", 1'b0, '0, 1'b1);
    rst_sys_ni = 1'b0;
    sb.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_rd = '0;
    #1;
    check_main("async_rst", 1'b0);
    @(posedge clk_sys_i); #1 rst_sys_ni = 1'b1;
    step("after_rst_wr", 1'b1, 32'h600, 1'b0);
    step("after_rst_rd", 1'b0, '0, 1'b1);

    fstep(1'b1, 8'h3C, 1'b0);
    chk("fwft.data", 32'(bus_f.rd_data_o), 32'h3C);
    chk("fwft.valid", 32'(bus_f.rd_valid_o), 32'd1);
    chk("fwft.level", 32'(bus_f.level_o), 32'd1);
    fstep(1'b0, 8'h00, 1'b0);
    chk("fwft.hold", 32'(bus_f.rd_data_o), 32'h3C);
    fstep(1'b0, 8'h00, 1'b1);
    chk("fwft.pop_empty", 32'(bus_f.empty_o), 32'd1);
    chk("fwft.pop_valid", 32'(bus_f.rd_valid_o), 32'd0);
    for (int i = 0; i < 5; i++) fstep(1'b1, 8'h10 + 8'(i), 1'b0);
    chk("fwft.full", 32'(bus_f.full_o), 32'd1);
    chk("fwft.afull", 32'(bus_f.almost_full_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("fwft.head", 32'(bus_f.rd_data_o), 32'h10 + 32'(i));
      fstep(1'b0, 8'h00, 1'b1);
    end
    chk("fwft.drained", 32'(bus_f.empty_o), 32'd1);
    chk("fwft.no_udf", 32'(bus_f.underflow_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
